// File: rtl/alu_issue_wb_if.sv
// Request/writeback bundle between an instruction source and alu_issue_wb.
// Latency: none, wires only.
// Backpressure: requester holds req_* while req_valid && !req_ready.
interface alu_issue_wb_if #(
  parameter int RW = 2
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [RW-1:0] req_dst;
  logic [RW-1:0] req_src_a;
  logic [RW-1:0] req_src_b;
  logic          req_imm_en;
  logic [7:0]    req_imm;
  logic          res_valid;
  logic [7:0]    res_data;

  modport master (
    output req_valid, req_op, req_dst, req_src_a, req_src_b, req_imm_en, req_imm,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_op, req_dst, req_src_a, req_src_b, req_imm_en, req_imm,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_issue_wb.sv
// Execute-stage controller: register file + one-at-a-time issue to an external registered 8-bit ALU.
// Latency: accept at edge N, ALU enabled in cycle N+1, writeback pulse in cycle N+2; one instr per 3 cycles.
// Backpressure: req_ready only in IDLE; requester holds the request otherwise. Optional debug read port: ALU_ISSUE_DBG_EN.
module alu_issue_wb #(
  parameter  int NREGS = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         reset,
  alu_issue_wb_if.slave bus,
  output logic         alu_enable,
  output logic [2:0]   alu_op,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  input  logic [7:0]   alu_out,
  input  logic         alu_carry,
`ifdef ALU_ISSUE_DBG_EN
  input  logic [RW-1:0] dbg_addr,
  output logic [7:0]    dbg_data,
`endif
  output logic         flag_z,
  output logic         flag_c
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    regs [NREGS];
  logic [2:0]    op_q;
  logic [RW-1:0] dst_q, src_a_q, src_b_q;
  logic          imm_en_q;
  logic [7:0]    imm_q;
  logic          accept;

  // Reset is folded in so no request is accepted while reset is held.
  assign accept = (state_q == IDLE) && bus.req_valid && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latch the instruction fields on accept; they stay stable through ISSUE and CAPTURE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      dst_q    <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
    end else if (accept) begin
      op_q     <= bus.req_op;
      dst_q    <= bus.req_dst;
      src_a_q  <= bus.req_src_a;
      src_b_q  <= bus.req_src_b;
      imm_en_q <= bus.req_imm_en;
      imm_q    <= bus.req_imm;
    end
  end

  // Writeback and flag update happen only at the end of CAPTURE; reset pre-empts both.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (state_q == CAPTURE) begin
      regs[dst_q] <= alu_out;
      flag_c      <= alu_carry;
      flag_z      <= (alu_out == 8'h00);
    end
  end

  // Next-state and per-state outputs; ALU operands are zeroed outside ISSUE.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = 8'h00;
    alu_enable    = 1'b0;
    alu_op        = 3'd0;
    alu_a         = 8'h00;
    alu_b         = 8'h00;
    case (state_q)
      IDLE: begin
        bus.req_ready = !reset;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        alu_enable = 1'b1;
        alu_op     = op_q;
        alu_a      = regs[src_a_q];
        alu_b      = imm_en_q ? imm_q : regs[src_b_q];
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        bus.res_valid = 1'b1;
        bus.res_data  = alu_out;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_ISSUE_DBG_EN
  // Side-band read of the register file; sees the pre-writeback value during CAPTURE.
  always_comb begin
    dbg_data = regs[dbg_addr];
  end
`endif

endmodule

// File: tb/tb_alu_issue_wb.sv
module tb_alu_issue_wb;
  logic       clk = 1'b0;
  logic       reset;
  logic       alu_enable;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       flag_z, flag_c;
`ifdef ALU_ISSUE_DBG_EN
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
`endif

  int passed = 0;
  int total  = 0;

  alu_issue_wb_if #(.RW(2)) bus ();

  alu_issue_wb #(.NREGS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_enable (alu_enable),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
`ifdef ALU_ISSUE_DBG_EN
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
`endif
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  always #5 clk = ~clk;

  // Registered 8-bit ALU; carry is a borrow for SUB/DEC and ADC consumes the stored carry.
  always @(posedge clk) begin
    if (reset) begin
      alu_out   <= 8'h00;
      alu_carry <= 1'b0;
    end else if (alu_enable) begin
      case (alu_op)
        3'd0: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
        3'd1: {alu_carry, alu_out} <= {1'b0, alu_a} - {1'b0, alu_b};
        3'd2: {alu_carry, alu_out} <= {1'b0, alu_a} + 9'd1;
        3'd3: {alu_carry, alu_out} <= {1'b0, alu_a} - 9'd1;
        3'd4: {alu_carry, alu_out} <= {1'b0, alu_a & alu_b};
        3'd5: {alu_carry, alu_out} <= {1'b0, alu_a | alu_b};
        3'd6: {alu_carry, alu_out} <= {1'b0, alu_a ^ alu_b};
        default: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry};
      endcase
    end
  end

  // Issue one request and return the writeback data and cycles from accept to res_valid.
  task automatic send(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                      input logic [1:0] sb, input logic ie, input logic [7:0] imm,
                      output logic [7:0] data, output int lat);
    int w;
    @(negedge clk);
    bus.req_op = op; bus.req_dst = dst; bus.req_src_a = sa; bus.req_src_b = sb;
    bus.req_imm_en = ie; bus.req_imm = imm; bus.req_valid = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 10) begin @(negedge clk); lat++; end
    data = bus.res_data;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.req_ready); else passed++;
    total++; if (flag_z !== 1'b0) $display("FAIL reset_flag_z got=%b exp=0", flag_z); else passed++;
    total++; if (flag_c !== 1'b0) $display("FAIL reset_flag_c got=%b exp=0", flag_c); else passed++;
    total++; if (alu_enable !== 1'b0) $display("FAIL reset_alu_enable got=%b exp=0", alu_enable); else passed++;
    total++; if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00)
      $display("FAIL reset_res got=%b/%h exp=0/00", bus.res_valid, bus.res_data); else passed++;
`ifdef ALU_ISSUE_DBG_EN
    for (int i = 0; i < 4; i++) begin
      dbg_addr = i[1:0];
      #1;
      total++; if (dbg_data !== 8'h00) $display("FAIL reset_reg%0d got=%h exp=00", i, dbg_data); else passed++;
    end
`endif
  endtask

  task automatic test_imm_add;
    logic [7:0] d; int lat;
    send(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h05, d, lat);
    total++; if (lat !== 2) $display("FAIL add_imm_latency got=%0d exp=2", lat); else passed++;
    total++; if (d !== 8'h05) $display("FAIL add_imm_data got=%h exp=05", d); else passed++;
    send(3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, d, lat);
    total++; if (d !== 8'h0A) $display("FAIL add_reg_data got=%h exp=0a", d); else passed++;
    @(negedge clk);
    total++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL add_reg_flags got=%b exp=00", {flag_z, flag_c}); else passed++;
  endtask

  task automatic test_carry_zero_adc;
    logic [7:0] d; int lat;
    send(3'd0, 2'd0, 2'd2, 2'd0, 1'b1, 8'hFF, d, lat);
    total++; if (d !== 8'hFF) $display("FAIL load_ff got=%h exp=ff", d); else passed++;
    send(3'd2, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00, d, lat);
    total++; if (d !== 8'h00) $display("FAIL inc_wrap_data got=%h exp=00", d); else passed++;
    @(negedge clk);
    total++; if ({flag_z, flag_c} !== 2'b11) $display("FAIL inc_wrap_flags got=%b exp=11", {flag_z, flag_c}); else passed++;
    send(3'd7, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, d, lat);
    total++; if (d !== 8'h01) $display("FAIL adc_data got=%h exp=01", d); else passed++;
    @(negedge clk);
    total++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL adc_flags got=%b exp=00", {flag_z, flag_c}); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [3];
    logic [1:0] dsts [3];
    logic [1:0] srcs [3];
    logic [7:0] imms [3];
    logic [7:0] exp_res [3];
    logic [7:0] res [3];
    int acc_cyc [3];
    int k, nacc, nen, nres;
    logic load_next;
    ops  = '{3'd6, 3'd5, 3'd4};
    dsts = '{2'd0, 2'd1, 2'd2};
    srcs = '{2'd1, 2'd0, 2'd1};
    imms = '{8'h0F, 8'h30, 8'h3C};
    exp_res = '{8'h05, 8'h35, 8'h34};
    res = '{8'h00, 8'h00, 8'h00};
    acc_cyc = '{0, 0, 0};
    k = 0; nacc = 0; nen = 0; nres = 0; load_next = 1'b0;
    @(negedge clk);
    bus.req_op = ops[0]; bus.req_dst = dsts[0]; bus.req_src_a = srcs[0]; bus.req_src_b = 2'd0;
    bus.req_imm_en = 1'b1; bus.req_imm = imms[0]; bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (load_next) begin
        k++;
        if (k < 3) begin
          bus.req_op = ops[k]; bus.req_dst = dsts[k]; bus.req_src_a = srcs[k]; bus.req_imm = imms[k];
        end else begin
          bus.req_valid = 1'b0;
        end
        load_next = 1'b0;
      end
      if (alu_enable) nen++;
      if (bus.res_valid) begin
        if (nres < 3) res[nres] = bus.res_data;
        nres++;
      end
      if (bus.req_ready && bus.req_valid) begin
        if (nacc < 3) acc_cyc[nacc] = cyc;
        nacc++;
        load_next = 1'b1;
      end
      @(negedge clk);
    end
    total++; if (nacc !== 3) $display("FAIL b2b_accepts got=%0d exp=3", nacc); else passed++;
    total++; if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3)
      $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); else passed++;
    total++; if (nen !== 3) $display("FAIL b2b_alu_enable_cycles got=%0d exp=3", nen); else passed++;
    total++; if (nres !== 3) $display("FAIL b2b_results got=%0d exp=3", nres); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (res[i] !== exp_res[i]) $display("FAIL b2b_data%0d got=%h exp=%h", i, res[i], exp_res[i]); else passed++;
    end
  endtask

  task automatic test_self_dep;
    logic [7:0] d; int lat;
    send(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'hCE, d, lat);
    total++; if (d !== 8'h03) $display("FAIL selfdep_load got=%h exp=03", d); else passed++;
    @(negedge clk);
    total++; if ({flag_z, flag_c} !== 2'b01) $display("FAIL selfdep_load_flags got=%b exp=01", {flag_z, flag_c}); else passed++;
    send(3'd1, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, d, lat);
    total++; if (d !== 8'h00) $display("FAIL selfdep_sub got=%h exp=00", d); else passed++;
    @(negedge clk);
    total++; if ({flag_z, flag_c} !== 2'b10) $display("FAIL selfdep_sub_flags got=%b exp=10", {flag_z, flag_c}); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; int lat, w;
    @(negedge clk);
    bus.req_op = 3'd0; bus.req_dst = 2'd0; bus.req_src_a = 2'd1; bus.req_src_b = 2'd0;
    bus.req_imm_en = 1'b1; bus.req_imm = 8'h33; bus.req_valid = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h33)
      $display("FAIL mid_capture got=%b/%h exp=1/33", bus.res_valid, bus.res_data); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b0) $display("FAIL mid_res_valid got=%b exp=0", bus.res_valid); else passed++;
    total++; if (flag_z !== 1'b0) $display("FAIL mid_flag_z got=%b exp=0", flag_z); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) $display("FAIL mid_idle_ready got=%b exp=1", bus.req_ready); else passed++;
`ifdef ALU_ISSUE_DBG_EN
    dbg_addr = 2'd0;
    #1;
    total++; if (dbg_data !== 8'h00) $display("FAIL mid_dbg_r0 got=%h exp=00", dbg_data); else passed++;
`endif
    send(3'd0, 2'd3, 2'd0, 2'd0, 1'b1, 8'h00, d, lat);
    total++; if (d !== 8'h00) $display("FAIL mid_r0_readback got=%h exp=00", d); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_dst = 2'd0; bus.req_src_a = 2'd0;
    bus.req_src_b = 2'd0; bus.req_imm_en = 1'b0; bus.req_imm = 8'h00;
`ifdef ALU_ISSUE_DBG_EN
    dbg_addr = 2'd0;
`endif
    test_reset;
    test_imm_add;
    test_carry_zero_adc;
    test_back_to_back;
    test_self_dep;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Execute-stage controller wrapped around the 8-bit ALU.
- Owns a small general-purpose register file and accepts one ALU instruction at a time over a valid/ready handshake.
- Reads operands, drives the ALU for exactly one enabled cycle, then captures the registered ALU result and carry one cycle later.
- Writes the result back to the destination register and keeps its own architectural zero/carry flags for the branch logic.

Parameters:
- NREGS, 4, number of 8-bit registers; power of two, at least 2.
- RW, $clog2(NREGS), register index width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  instruction request valid.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_op  input  3  ALU opcode, passed through unchanged: ADD=0, SUB=1, INC=2, DEC=3, AND=4, OR=5, XOR=6, ADC=7.
- req_dst  input  RW  destination register index.
- req_src_a  input  RW  operand A register index.
- req_src_b  input  RW  operand B register index.
- req_imm_en  input  1  when 1, req_imm replaces operand B.
- req_imm  input  8  immediate operand.
- alu_enable  output  1  ALU enable.
- alu_op  output  3  ALU opcode.
- alu_a  output  8  ALU operand A.
- alu_b  output  8  ALU operand B.
- alu_out  input  8  registered ALU result.
- alu_carry  input  1  registered ALU carry.
- res_valid  output  1  one-cycle pulse; writeback happening this cycle.
- res_data  output  8  value being written back; valid with res_valid.
- flag_z  output  1  architectural zero flag.
- flag_c  output  1  architectural carry flag.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Values on reset:
  - State goes to IDLE.
  - All registers, latched fields, flag_z and flag_c clear to 0.
  - alu_enable, res_valid and res_data are 0; req_ready becomes 1 the cycle after reset deasserts.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch op, dst, src_a, src_b, imm_en and imm, then go to ISSUE.
  - req_valid with req_ready=0 is ignored; the requester holds the request.
- ISSUE (exactly one cycle):
  - alu_enable=1, alu_op = latched op.
  - alu_a = reg[src_a]; alu_b = imm_en ? imm : reg[src_b].
  - Next state CAPTURE.
- CAPTURE (exactly one cycle):
  - alu_out and alu_carry now hold the ISSUE-cycle result.
  - res_valid=1, res_data=alu_out.
  - At the edge: reg[dst] <= alu_out, flag_c <= alu_carry, flag_z <= (alu_out == 0).
  - Next state IDLE.
- alu_enable is 0 in every state except ISSUE; alu_a, alu_b and alu_op are don't-care outside ISSUE but driven to 0.
- Latency: request accepted at edge N; ISSUE in cycle N+1; writeback at end of cycle N+2; new value readable from cycle N+3, which is also when the next accept can occur. Throughput is one instruction per 3 cycles.
- No hazards: the next accept cannot precede writeback, so operand reads always see the prior result.
- src_a, src_b and dst may all be equal; the read happens in ISSUE and the write in CAPTURE.
- flag_z is computed locally from the captured result; the ALU's own zero output is not used.
- Flags change only in CAPTURE; every op, including AND/OR/XOR, updates both flags.
- Reset during ISSUE or CAPTURE: no writeback and no flag update. The ALU shares the reset, so its internal carry also clears.
- Register indices are exactly RW bits, so there are no out-of-range indices.

Optional Feature:
- Macro: ALU_ISSUE_DBG_EN.
- Defined: adds input dbg_addr [RW] and output dbg_data [8].
  - dbg_data = reg[dbg_addr], combinational, with no effect on the FSM.
  - A read of reg[dst] during CAPTURE returns the old value.
- Undefined: these ports are absent and there is no extra logic.

Test Plan:
- Reset then idle: hold reset 2 cycles, release → req_ready=1, flag_z=0, flag_c=0, alu_enable=0, all regs 0 (checked via ALU_ISSUE_DBG_EN).
- Immediate load then add:
  - ADD r0 = r0 + imm 0x05 → res_data=0x05 two cycles after accept.
  - Then ADD r1 = r0 + r0 → r1=0x0A, flag_z=0, flag_c=0.
- Carry, zero and ADC chain:
  - r0=0xFF via imm, then INC r2 = r0 → res_data=0x00, flag_z=1, flag_c=1.
  - Then ADC r3 = r2 + imm 0x00 → r3=0x01.
- Back-to-back pressure:
  - Hold req_valid high with 3 queued requests → exactly one accept every 3 cycles.
  - alu_enable high for exactly 1 cycle per instruction; no request lost or duplicated.
- Self-dependency: r1=0x03, SUB r1 = r1 - r1 → r1=0x00, flag_z=1, flag_c=0.
- Reset mid-operation: assert reset during CAPTURE of ADD r0 = imm 0x33 → r0 stays 0x00, res_valid=0 from the next cycle, state returns to IDLE.
